load_store_unit: RTL and testbench

- Sequential load/store front-end sitting directly upstream of the word-addressed data memory in the single-cycle/multi-cycle RISC-V datapath.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) and drives word-aligned memory accesses.
- Performs byte/half extraction with sign/zero extension on loads, and read-modify-write for sub-word stores.
- Flags misaligned, illegal-funct3 and out-of-range accesses; raises a stall (req_ready low) while busy.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and fault detection for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic lsu_fault(input logic we, input logic [2:0] funct3,
                                     input logic [31:0] addr, input int unsigned mem_words);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (we) illegal = (funct3 > F3_W);
    else    illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                   ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= mem_words);
    return illegal || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane extraction with extension for loads, lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = '0;
    case (addr_lo)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = '0;
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      default: load_data = word;
    endcase

    store_word = word;
    if (funct3 == F3_B) begin
      case (addr_lo)
        2'd0: store_word[7:0]   = wdata[7:0];
        2'd1: store_word[15:8]  = wdata[7:0];
        2'd2: store_word[23:16] = wdata[7:0];
        2'd3: store_word[31:24] = wdata[7:0];
        default: store_word = word;
      endcase
    end else if (funct3 == F3_H) begin
      if (addr_lo[1]) store_word[31:16] = wdata;
      else            store_word[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front-end: request capture, fault checks and word-aligned memory sequencing.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  lsu_state_t  state, state_nx;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_err;
  logic [31:0] load_q;
  logic [31:0] merged_q;
  logic [31:0] align_load;
  logic [31:0] align_store;
  logic        req_fault;

  assign req_fault = lsu_fault(req_we, req_funct3, req_addr, MEM_WORDS);

  lsu_align u_align (
    .word       (mem_rdata),
    .wdata      (cap_wdata[15:0]),
    .addr_lo    (cap_addr[1:0]),
    .funct3     (cap_f3),
    .load_data  (align_load),
    .store_word (align_store)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we    <= 1'b0;
      cap_f3    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_err   <= 1'b0;
      load_q    <= '0;
      merged_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cap_we    <= req_we;
          cap_f3    <= req_funct3;
          cap_addr  <= req_addr;
          cap_wdata <= req_wdata;
          cap_err   <= req_fault;
          load_q    <= '0;
        end
        S_ACCESS: begin
          if (!cap_we) load_q   <= align_load;
          else         merged_q <= align_store;
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs are pure state decodes so an async reset drops them at once.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_fault ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        mem_addr = {cap_addr[31:2], 2'b00};
        if (cap_we && cap_f3 == F3_W) begin
          mem_we    = 1'b1;
          mem_wdata = cap_wdata;
          state_nx  = S_DONE;
        end else if (cap_we) begin
          state_nx = S_WRITE;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_WRITE: begin
        mem_addr  = {cap_addr[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = merged_q;
        state_nx  = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = cap_err;
        rsp_rdata = (cap_err || cap_we) ? '0 : load_q;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed checks of load_store_unit against a word-array reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  logic        init_req;
  int unsigned we_cnt;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;

  int unsigned checks;
  int unsigned failures;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (init_req) begin
      mem <= ref_mem;
    end else if (mem_we) begin
      mem[mem_addr[6:2]] <= mem_wdata;
      we_cnt     <= we_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_fault(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit illegal, mis, oor;
    illegal = we ? (f3 > 2) : (f3 == 3 || f3 >= 6);
    mis     = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
    oor     = (a / 4) >= 32;
    return illegal || mis || oor;
  endfunction

  function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a);
    bit [31:0] w, b, h;
    w = ref_mem[a / 4];
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> ((a % 4) * 8)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit [31:0] ref_store(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    bit [31:0] w, mask;
    w = ref_mem[a / 4];
    if (f3 == 2) return wd;
    mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << ((a % 4) * 8);
    return (w & ~mask) | ((wd << ((a % 4) * 8)) & mask);
  endfunction

  task automatic do_req(input string tag, input bit we, input bit [2:0] f3,
                        input bit [31:0] a, input bit [31:0] wd);
    bit          flt;
    bit [31:0]   exp_rd;
    int unsigned exp_lat, exp_we, lat, w0;
    logic        got_err;
    logic [31:0] got_rd;
    flt     = ref_fault(we, f3, a);
    exp_rd  = (flt || we) ? 32'h0 : ref_load(f3, a);
    exp_lat = flt ? 1 : ((we && f3 != 2) ? 3 : 2);
    exp_we  = (flt || !we) ? 0 : 1;
    w0      = we_cnt;
    @(negedge clk);
    check_eq({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0; got_err = 1'bx; got_rd = 'x;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n; got_err = rsp_err; got_rd = rsp_rdata;
      end
    end
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".err"}, {31'h0, got_err}, {31'h0, flt});
    check_eq({tag, ".rdata"}, got_rd, exp_rd);
    check_eq({tag, ".we_pulses"}, we_cnt - w0, exp_we);
    @(negedge clk);
    check_eq({tag, ".pulse_once"}, {31'h0, rsp_valid}, 32'h0);
    if (!flt && we) ref_mem[a / 4] = ref_store(f3, a, wd);
    if (a / 4 < 32) check_eq({tag, ".memword"}, mem[a / 4], ref_mem[a / 4]);
  endtask

  initial begin
    bit [31:0]   a;
    bit [2:0]    f3;
    bit          we;
    int unsigned w0, pulses;
    checks = 0; failures = 0; we_cnt = 0;
    last_waddr = '0; last_wdata = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; init_req = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[1] = 32'h80FF_7F01;
    ref_mem[2] = 32'h1122_3344;
    init_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 init_req = 1'b0;

    check_eq("rst.ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst.rsp_err", {31'h0, rsp_err}, 32'h0);
    check_eq("rst.mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rst.rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst.mem_addr", mem_addr, 32'h0);
    check_eq("rst.mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("lb7", 1'b0, 3'd0, 32'h7, 32'h0);
    do_req("lbu7", 1'b0, 3'd4, 32'h7, 32'h0);
    do_req("lh4", 1'b0, 3'd1, 32'h4, 32'h0);
    do_req("lh6", 1'b0, 3'd1, 32'h6, 32'h0);
    do_req("sb9", 1'b1, 3'd0, 32'h9, 32'h0000_00AB);
    check_eq("sb9.waddr", last_waddr, 32'h8);
    check_eq("sb9.wdata", last_wdata, 32'h1122_AB44);
    do_req("lw8", 1'b0, 3'd2, 32'h8, 32'h0);
    do_req("sw6_misal", 1'b1, 3'd2, 32'h6, 32'hDEAD_BEEF);
    do_req("lw80_oor", 1'b0, 3'd2, 32'h80, 32'h0);
    do_req("ld_f3_011", 1'b0, 3'd3, 32'h0, 32'h0);

    // Stall: req_valid stays high across two loads
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check_eq("stall.ready_access", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    check_eq("stall.ready_done", {31'h0, req_ready}, 32'h0);
    check_eq("stall.rsp1_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("stall.rsp1_data", rsp_rdata, ref_mem[0]);
    req_addr = 32'h4;
    @(negedge clk);
    check_eq("stall.ready_idle", {31'h0, req_ready}, 32'h1);
    check_eq("stall.idle_no_rsp", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_eq("stall.ready_access2", {31'h0, req_ready}, 32'h0);
    check_eq("stall.access2_no_rsp", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check_eq("stall.rsp2_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("stall.rsp2_data", rsp_rdata, ref_mem[1]);
    req_valid = 1'b0;
    @(negedge clk);

    // Reset while SH is in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h2; req_wdata = 32'h0000_5A5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid.mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rstmid.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rstmid.ready", {31'h0, req_ready}, 32'h1);
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check_eq("rstmid.no_rsp", pulses, 0);
    check_eq("rstmid.no_write", we_cnt - w0, 0);
    check_eq("rstmid.memword", mem[0], ref_mem[0]);

    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = ($urandom_range(0, 35) * 4) + $urandom_range(0, 3);
      do_req("rand", we, f3, a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%08h exp=%08h", 32'h0, 32'h1);
    $fatal(1, "timeout");
  end

endmodule
